// File: rtl/mac_array_db_if.sv
// mac_array_db_if: west/north feed and south result bus of the MAC array.
// The master side drives activations, weights, partial sums and
// instructions; the slave side (the array) returns south psums and valids.
interface mac_array_db_if #(
   parameter int BW      = 4,
   parameter int PSUM_BW = 16,
   parameter int ROW     = 8,
   parameter int COL     = 8
);
   logic [ROW*BW-1:0]      in_w;
   logic [COL*PSUM_BW-1:0] in_n;
   logic [2:0]             inst_w;
   logic                   mode_2bit;
   logic [COL*PSUM_BW-1:0] out_s;
   logic [COL-1:0]         valid;

   modport master (
      output in_w, in_n, inst_w, mode_2bit,
      input  out_s, valid
   );

   modport slave (
      input  in_w, in_n, inst_w, mode_2bit,
      output out_s, valid
   );
endinterface

// File: rtl/mac_array_db.sv
// mac_array_db: weight-stationary ROW x COL systolic MAC array with
// double-buffered (shadow) weights. Activations move west->east, psums
// north->south, instructions are skewed one cycle per row and per column.
// Optional feature macro: SIMD2_EN enables the 2-bit dual-lane product
// selected by mode_2bit; without it mode_2bit is ignored.
module mac_array_db #(
   parameter int BW      = 4,
   parameter int PSUM_BW = 16,
   parameter int ROW     = 8,
   parameter int COL     = 8
) (
   input logic            clk,
   input logic            reset,
   mac_array_db_if.slave  bus
);

   localparam int HB = BW / 2;

   // Instruction word layout: [2] swap, [1] execute, [0] load.
   typedef struct packed {
      logic swap;
      logic exec;
      logic load;
   } inst_t;

   inst_t              inst_q   [ROW];
   inst_t              inst_fwd [ROW][COL];
   logic [BW-1:0]      a_q      [ROW][COL];
   logic [BW-1:0]      w_act    [ROW][COL];
   logic [BW-1:0]      w_shd    [ROW][COL];
   logic [PSUM_BW-1:0] psum_q   [ROW][COL];
   logic               valid_q  [ROW][COL];
   logic               ready_q  [ROW][COL];

   // Row skew: instruction enters row 0 one cycle after issue, then moves down a row per cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < ROW; r++) inst_q[r] <= '0;
      end else begin
         // NOTE: non-blocking assignments make this a true shift register; with blocking
         // assignments every stage would receive the new instruction in the same cycle.
         inst_q[0] <= inst_t'(bus.inst_w);
         for (int r = 1; r < ROW; r++) inst_q[r] <= inst_q[r-1];
      end
   end

   for (genvar r = 0; r < ROW; r++) begin : g_row
      for (genvar c = 0; c < COL; c++) begin : g_col
         inst_t              inst_in;
         logic [BW-1:0]      a_in;
         logic [PSUM_BW-1:0] n_in;
         logic [PSUM_BW-1:0] prod;

         if (c == 0) begin : g_west_edge
            assign inst_in = inst_q[r];
            assign a_in    = bus.in_w[r*BW +: BW];
         end else begin : g_west_pe
            assign inst_in = inst_fwd[r][c-1];
            assign a_in    = a_q[r][c-1];
         end

         if (r == 0) begin : g_north_edge
            assign n_in = bus.in_n[c*PSUM_BW +: PSUM_BW];
         end else begin : g_north_pe
            assign n_in = psum_q[r-1][c];
         end

         // Product of signed active weight and unsigned activation, sign-extended to PSUM_BW.
         always_comb begin
            logic [PSUM_BW-1:0] w_ext;
            logic [PSUM_BW-1:0] a_ext;
            // NOTE: every variable gets a value before any condition, so no latch is inferred.
            w_ext = {{(PSUM_BW-BW){w_act[r][c][BW-1]}}, w_act[r][c]};
            a_ext = {{(PSUM_BW-BW){1'b0}}, a_in};
            prod  = w_ext * a_ext;
`ifdef SIMD2_EN
            if (bus.mode_2bit) begin
               prod = {{(PSUM_BW-HB){w_act[r][c][BW-1]}}, w_act[r][c][BW-1:HB]}
                    * {{(PSUM_BW-HB){1'b0}}, a_in[BW-1:HB]}
                    + {{(PSUM_BW-HB){w_act[r][c][HB-1]}}, w_act[r][c][HB-1:0]}
                    * {{(PSUM_BW-HB){1'b0}}, a_in[HB-1:0]};
            end
`endif
         end

         // PE state: activation pass-through, shadow load, swap, accumulate, instruction forward.
         always_ff @(posedge clk) begin
            if (reset) begin
               // NOTE: weights and psums are cleared on reset so nothing from a dropped kernel
               // leaks out; ready_q comes up armed so the first load lands in column 0.
               a_q[r][c]      <= '0;
               w_act[r][c]    <= '0;
               w_shd[r][c]    <= '0;
               psum_q[r][c]   <= '0;
               valid_q[r][c]  <= 1'b0;
               ready_q[r][c]  <= 1'b1;
               inst_fwd[r][c] <= '0;
            end else begin
               a_q[r][c]     <= a_in;
               valid_q[r][c] <= inst_in.exec;
               if (inst_in.exec)
                  psum_q[r][c] <= n_in + prod;
               if (inst_in.load && ready_q[r][c])
                  w_shd[r][c] <= a_in;
               if (inst_in.swap) begin
                  w_act[r][c]   <= w_shd[r][c];
                  ready_q[r][c] <= 1'b1;
               end else if (inst_in.load && ready_q[r][c]) begin
                  ready_q[r][c] <= 1'b0;
               end
               inst_fwd[r][c] <= '{swap: inst_in.swap,
                                   exec: inst_in.exec,
                                   load: inst_in.load & ~ready_q[r][c]};
            end
         end
      end
   end

`ifndef SIMD2_EN
   logic unused_mode_2bit;
   assign unused_mode_2bit = bus.mode_2bit;
`endif

   // South edge: bottom-row psums and valids, forced to zero while reset is held.
   always_comb begin
      bus.out_s = '0;
      bus.valid = '0;
      if (!reset) begin
         for (int c = 0; c < COL; c++) begin
            bus.out_s[c*PSUM_BW +: PSUM_BW] = psum_q[ROW-1][c];
            bus.valid[c]                    = valid_q[ROW-1][c];
         end
      end
   end

endmodule

// File: tb/tb_mac_array_db.sv
// tb_mac_array_db: directed bench for mac_array_db. A reference model tracks
// active/shadow weights in instruction order; expected south results are
// queued per column at issue time and compared when the cycle comes.
module tb_mac_array_db;

   localparam int BW      = 4;
   localparam int PSUM_BW = 16;
   localparam int ROW     = 8;
   localparam int COL     = 8;
   localparam int MAXC    = 512;

   localparam logic [2:0] I_LOAD = 3'b001;
   localparam logic [2:0] I_EXEC = 3'b010;
   localparam logic [2:0] I_SWAP = 3'b100;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mac_array_db_if bus ();

   mac_array_db dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int          cyc;
      logic [15:0] val;
   } exp_t;

   exp_t        exp_q [COL][$];
   logic [3:0]  w_tab [MAXC][ROW];
   logic [15:0] n_tab [MAXC][COL];
   logic [3:0]  m_act [ROW][COL];
   logic [3:0]  m_shd [ROW][COL];
   logic        m_rdy [ROW][COL];

   int         cyc;
   int         passed;
   int         total;
   logic [2:0] inst_cur;
   logic       mode;
   logic       chk_zero;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      total++;
      assert (obs === expv) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
   endtask

   function automatic logic [15:0] prod_model(input logic [3:0] w, input logic [3:0] a,
                                              input logic m);
      logic       use_simd;
      logic [1:0] w_hi, w_lo;
      int         wh, wl, ah, al;
`ifdef SIMD2_EN
      use_simd = m;
`else
      use_simd = 1'b0 & m;
`endif
      if (use_simd) begin
         w_hi = w[3:2];
         w_lo = w[1:0];
         wh   = int'($signed(w_hi));
         wl   = int'($signed(w_lo));
         ah   = int'(a[3:2]);
         al   = int'(a[1:0]);
         return 16'(wh * ah + wl * al);
      end
      return 16'(int'($signed(w)) * int'(a));
   endfunction

   task automatic model_reset();
      for (int r = 0; r < ROW; r++)
         for (int c = 0; c < COL; c++) begin
            m_act[r][c] = '0;
            m_shd[r][c] = '0;
            m_rdy[r][c] = 1'b1;
         end
      for (int c = 0; c < COL; c++) exp_q[c].delete();
   endtask

   // Issue one instruction this cycle: schedule skewed data and update the model.
   task automatic issue(input logic [2:0] inst, input logic [3:0] a, input int a_step,
                        input logic [15:0] n, input int n_step);
      logic [3:0]  a_r [ROW];
      logic [15:0] sum;
      exp_t        e;
      inst_cur = inst;
      for (int r = 0; r < ROW; r++) begin
         a_r[r] = 4'(int'(a) + r * a_step);
         w_tab[cyc+1+r][r] = a_r[r];
      end
      for (int c = 0; c < COL; c++)
         n_tab[cyc+1+c][c] = 16'(int'(n) + c * n_step);
      if (inst[1]) begin
         for (int c = 0; c < COL; c++) begin
            sum = 16'(int'(n) + c * n_step);
            for (int r = 0; r < ROW; r++) sum = sum + prod_model(m_act[r][c], a_r[r], mode);
            e.cyc = cyc + ROW + c + 1;
            e.val = sum;
            exp_q[c].push_back(e);
         end
      end
      if (inst[2])
         for (int r = 0; r < ROW; r++)
            for (int c = 0; c < COL; c++) m_act[r][c] = m_shd[r][c];
      if (inst[0])
         for (int r = 0; r < ROW; r++) begin
            for (int c = 0; c < COL; c++)
               if (m_rdy[r][c]) begin
                  m_shd[r][c] = a_r[r];
                  m_rdy[r][c] = 1'b0;
                  break;
               end
         end
      if (inst[2])
         for (int r = 0; r < ROW; r++)
            for (int c = 0; c < COL; c++) m_rdy[r][c] = 1'b1;
   endtask

   // Drive this cycle's inputs, check outputs mid-cycle, advance past the edge.
   task automatic cycle();
      bus.inst_w    = inst_cur;
      bus.mode_2bit = mode;
      for (int r = 0; r < ROW; r++) bus.in_w[r*BW +: BW] = w_tab[cyc][r];
      for (int c = 0; c < COL; c++) bus.in_n[c*PSUM_BW +: PSUM_BW] = n_tab[cyc][c];
      @(negedge clk);
      if (reset) begin
         check("reset out_s", bus.out_s, '0);
         check("reset valid", bus.valid, '0);
      end else begin
         if (chk_zero) check("post-reset out_s", bus.out_s, '0);
         for (int c = 0; c < COL; c++) begin
            if (exp_q[c].size() > 0 && exp_q[c][0].cyc == cyc) begin
               check($sformatf("valid[%0d] cyc %0d", c, cyc), bus.valid[c], 1'b1);
               check($sformatf("out_s[%0d] cyc %0d", c, cyc),
                     bus.out_s[c*PSUM_BW +: PSUM_BW], exp_q[c][0].val);
               void'(exp_q[c].pop_front());
            end else begin
               check($sformatf("idle valid[%0d] cyc %0d", c, cyc), bus.valid[c], 1'b0);
            end
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      inst_cur = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) cycle();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      passed   = 0;
      total    = 0;
      cyc      = 0;
      mode     = 1'b0;
      inst_cur = '0;
      chk_zero = 1'b0;
      for (int k = 0; k < MAXC; k++) begin
         for (int r = 0; r < ROW; r++) w_tab[k][r] = 4'($urandom);
         for (int c = 0; c < COL; c++) n_tab[k][c] = 16'($urandom);
      end
      model_reset();

      // Reset held two cycles with random instructions and mode.
      reset = 1'b1;
      repeat (2) begin
         inst_cur = 3'($urandom);
         mode     = 1'($urandom);
         cycle();
      end
      reset = 1'b0;
      mode  = 1'b0;

      // Basic: all-ones kernel, one execute with activation 1 -> 8 per column.
      repeat (COL) begin issue(I_LOAD, 4'h1, 0, 16'd0, 0); cycle(); end
      issue(I_SWAP, 4'h0, 0, 16'd0, 0); cycle();
      issue(I_EXEC, 4'h1, 0, 16'd0, 0); cycle();
      idle(ROW + COL + 2);

      // Signed wrap: weight -1, activation 15, in_n 100; swap shares the last load.
      repeat (COL - 1) begin issue(I_LOAD, 4'hF, 0, 16'd0, 0); cycle(); end
      issue(I_LOAD | I_SWAP, 4'hF, 0, 16'd0, 0); cycle();
      issue(I_EXEC, 4'hF, 0, 16'd100, 0); cycle();
      idle(ROW + COL + 2);

      // Double buffer: weight 2 active, shadow 3 loaded under continuous execute.
      repeat (COL) begin issue(I_LOAD, 4'h2, 0, 16'd0, 0); cycle(); end
      issue(I_SWAP, 4'h0, 0, 16'd0, 0); cycle();
      repeat (2) begin issue(I_EXEC, 4'h1, 0, 16'd0, 0); cycle(); end
      repeat (COL) begin issue(I_LOAD | I_EXEC, 4'h3, 0, 16'd0, 0); cycle(); end
      issue(I_LOAD | I_EXEC, 4'h7, 0, 16'd0, 0); cycle();
      issue(I_SWAP | I_EXEC, 4'h1, 0, 16'd0, 0); cycle();
      repeat (3) begin issue(I_EXEC, 4'h1, 0, 16'd0, 0); cycle(); end
      idle(ROW + COL + 2);

      // SIMD mode: weight 0111, activation 1001.
      mode = 1'b1;
      repeat (COL) begin issue(I_LOAD, 4'h7, 0, 16'd0, 0); cycle(); end
      issue(I_SWAP, 4'h0, 0, 16'd0, 0); cycle();
      issue(I_EXEC, 4'h9, 0, 16'd0, 0); cycle();
      idle(ROW + COL + 2);
      mode = 1'b0;

      // Reset mid-stream: four executes in flight are dropped.
      repeat (4) begin issue(I_EXEC, 4'h1, 0, 16'd0, 0); cycle(); end
      idle(2);
      reset = 1'b1;
      model_reset();
      cycle();
      reset    = 1'b0;
      chk_zero = 1'b1;
      cycle();
      chk_zero = 1'b0;
      idle(ROW + COL + 2);

      // Weights are gone after reset: an execute returns in_n unchanged.
      issue(I_EXEC, 4'h5, 0, 16'd30, 7); cycle();
      idle(ROW + COL + 2);

      // Clean reload with per-row weights and activations, per-column in_n.
      repeat (COL) begin issue(I_LOAD, 4'h2, 1, 16'd0, 0); cycle(); end
      issue(I_SWAP, 4'h0, 0, 16'd0, 0); cycle();
      issue(I_EXEC, 4'h3, 2, 16'd5, 3); cycle();
      issue(I_EXEC, 4'hA, 3, 16'hFFF0, 1); cycle();
      idle(ROW + COL + 2);

      for (int c = 0; c < COL; c++)
         check($sformatf("unseen results col %0d", c), exp_q[c].size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
